debug_spi_master: RTL and testbench

- Host side of the CDM16 debug SPI link. It issues one 40-bit debug frame per request to the board's debug SPI slave: 8-bit command, 16-bit address, 16-bit data.
- It captures the slave's 16-bit reply and returns it on a response strobe.
- Used by an on-chip test sequencer or bridge to load memory, read registers and reset the CPU without an external probe.
- Drives SCK slowly enough for the slave's system-clock edge detector: SPI mode 0, MSB first.

---
 rtl/debug_spi_pkg.sv | 33 +++
 rtl/debug_spi_master_if.sv | 17 +
 rtl/debug_spi_bit_timer.sv | 31 +++
 rtl/debug_spi_master.sv | 172 +++++++++++++++++
 tb/tb_debug_spi_master.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_spi_pkg.sv
// ---------------------------------------------------------------------------
// debug_spi_pkg : shared constants and state type for the CDM16 debug SPI host
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package debug_spi_pkg;

  localparam logic [7:0] CMD_REG_READ  = 8'd1;
  localparam logic [7:0] CMD_RESET_SET = 8'd2;
  localparam logic [7:0] CMD_MEM_WRITE = 8'd3;
  localparam logic [7:0] CMD_MEM_READ  = 8'd4;

  localparam logic [15:0] REG_SP  = 16'd8;
  localparam logic [15:0] REG_PC  = 16'd9;
  localparam logic [15:0] REG_PS  = 16'd10;
  localparam logic [15:0] REG_STA = 16'd11;

  localparam int FRAME_BITS      = 40;
  localparam int REPLY_FIRST_BIT = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    TAIL  = 3'd4,
    GAP   = 3'd5
  } spi_state_e;

endpackage

`default_nettype wire

// File: rtl/debug_spi_master_if.sv
// ---------------------------------------------------------------------------
// debug_spi_master_if : four-wire debug SPI link between host and board slave
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface debug_spi_master_if;
  logic CLK;
  logic CS;
  logic MOSI;
  logic MISO;

  modport master (output CLK, output CS, output MOSI, input MISO);
  modport slave  (input CLK, input CS, input MOSI, output MISO);
endinterface

`default_nettype wire

// File: rtl/debug_spi_bit_timer.sv
// ---------------------------------------------------------------------------
// debug_spi_bit_timer : loadable down-counter, done while the count sits at 0
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module debug_spi_bit_timer (
  input  wire logic       system_clock,
  input  wire logic       reset,
  input  wire logic       load,
  input  wire logic [7:0] load_val,
  output logic            done
);

  logic [7:0] r_count;

  always_ff @(posedge system_clock) begin
    if (!reset) begin
      r_count <= 8'd0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != 8'd0) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign done = (r_count == 8'd0);

endmodule

`default_nettype wire

// File: rtl/debug_spi_master.sv
// ---------------------------------------------------------------------------
// debug_spi_master : issues 40-bit debug frames (mode 0, MSB first), returns
//                    the 16-bit reply. Option: DEBUG_SPI_MISO_SYNC_EN.
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module debug_spi_master
  import debug_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_TAIL = 4,
  parameter int CS_GAP  = 4
) (
  input  wire logic          system_clock,
  input  wire logic          reset,
  input  wire logic          req_valid,
  output logic               req_ready,
  input  wire logic [7:0]    req_cmd,
  input  wire logic [15:0]   req_addr,
  input  wire logic [15:0]   req_data,
  output logic               rsp_valid,
  output logic [15:0]        rsp_data,
  output logic               busy,
  debug_spi_master_if.master spi
);

  localparam logic [7:0] c_half_m1     = 8'(CLK_DIV - 1);
  localparam logic [7:0] c_tail_m1     = 8'(CS_TAIL - 1);
  localparam logic [7:0] c_gap_m1      = 8'(CS_GAP - 1);
  localparam logic [5:0] c_last_bit    = 6'(FRAME_BITS - 1);
  localparam logic [5:0] c_first_reply = 6'(REPLY_FIRST_BIT);

  spi_state_e  r_state;
  logic [39:0] r_shift;
  logic [5:0]  r_bit_cnt;
  logic [15:0] r_reply;
  logic        r_cs;
  logic        r_sck;
  logic        w_accept;
  logic        w_done;
  logic        w_load;
  logic [7:0]  w_load_val;
  logic        w_sample;
  logic        w_miso;
  logic        w_capture;

  assign w_accept = req_valid && req_ready;

  debug_spi_bit_timer u_timer (
    .system_clock (system_clock),
    .reset        (reset),
    .load         (w_load),
    .load_val     (w_load_val),
    .done         (w_done)
  );

  always_comb begin
    w_load     = 1'b0;
    w_load_val = c_half_m1;
    case (r_state)
      IDLE:        w_load = w_accept;
      SETUP, HIGH: w_load = w_done;
      LOW: begin
        w_load = w_done;
        if (r_bit_cnt == c_last_bit) w_load_val = c_tail_m1;
      end
      TAIL: begin
        w_load     = w_done;
        w_load_val = c_gap_m1;
      end
      default: w_load = 1'b0;
    endcase
  end

`ifdef DEBUG_SPI_MISO_SYNC_EN
  logic r_miso_s1;
  logic r_miso_s2;

  always_ff @(posedge system_clock) begin
    if (!reset) begin
      r_miso_s1 <= 1'b0;
      r_miso_s2 <= 1'b0;
    end else begin
      r_miso_s1 <= spi.MISO;
      r_miso_s2 <= r_miso_s1;
    end
  end

  // Two-flop delay is absorbed by sampling at the end of the high phase.
  assign w_miso   = r_miso_s2;
  assign w_sample = (r_state == HIGH) && w_done;
`else
  logic r_sck_d;

  always_ff @(posedge system_clock) begin
    if (!reset) r_sck_d <= 1'b0;
    else        r_sck_d <= r_sck;
  end

  assign w_miso   = spi.MISO;
  assign w_sample = r_sck && !r_sck_d;
`endif

  assign w_capture = w_sample && (r_bit_cnt >= c_first_reply);

  always_ff @(posedge system_clock) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_shift   <= 40'd0;
      r_bit_cnt <= 6'd0;
      r_reply   <= 16'd0;
      r_cs      <= 1'b1;
      r_sck     <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= 16'd0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (w_capture) r_reply <= {r_reply[14:0], w_miso};
      case (r_state)
        IDLE: if (w_accept) begin
          r_shift   <= {req_cmd, req_addr, req_data};
          r_bit_cnt <= 6'd0;
          r_cs      <= 1'b0;
          req_ready <= 1'b0;
          busy      <= 1'b1;
          r_state   <= SETUP;
        end
        SETUP: if (w_done) begin
          r_sck   <= 1'b1;
          r_state <= HIGH;
        end
        // MOSI is r_shift[39]; shifting on every fall leaves it 0 after bit 39.
        HIGH: if (w_done) begin
          r_sck   <= 1'b0;
          r_shift <= {r_shift[38:0], 1'b0};
          r_state <= LOW;
        end
        LOW: if (w_done) begin
          if (r_bit_cnt == c_last_bit) begin
            r_state <= TAIL;
          end else begin
            r_bit_cnt <= r_bit_cnt + 6'd1;
            r_sck     <= 1'b1;
            r_state   <= HIGH;
          end
        end
        TAIL: if (w_done) begin
          r_cs      <= 1'b1;
          rsp_valid <= 1'b1;
          rsp_data  <= r_reply;
          r_state   <= GAP;
        end
        GAP: if (w_done) begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign spi.CS   = r_cs;
  assign spi.CLK  = r_sck;
  assign spi.MOSI = r_shift[39];

endmodule

`default_nettype wire

// File: tb/tb_debug_spi_master.sv
// ---------------------------------------------------------------------------
// tb_debug_spi_master : scoreboard bench with a behavioural debug SPI slave
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_debug_spi_master;
  import debug_spi_pkg::*;

`ifdef DEBUG_SPI_MISO_SYNC_EN
  localparam int TB_CLK_DIV = 8;
`else
  localparam int TB_CLK_DIV = 4;
`endif
  localparam int TB_CS_TAIL = 4;
  localparam int TB_CS_GAP  = 4;
  localparam int LAT        = 1 + TB_CLK_DIV * 81 + TB_CS_TAIL;

  logic        system_clock = 1'b0;
  logic        reset        = 1'b0;
  logic        req_valid    = 1'b0;
  logic        req_ready;
  logic [7:0]  req_cmd      = 8'd0;
  logic [15:0] req_addr     = 16'd0;
  logic [15:0] req_data     = 16'd0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        busy;

  debug_spi_master_if spi ();

  debug_spi_master #(
    .CLK_DIV (TB_CLK_DIV),
    .CS_TAIL (TB_CS_TAIL),
    .CS_GAP  (TB_CS_GAP)
  ) dut (
    .system_clock (system_clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_cmd      (req_cmd),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .busy         (busy),
    .spi          (spi)
  );

  initial forever #5 system_clock = ~system_clock;

  typedef struct {
    logic [39:0] frame;
    logic [15:0] reply;
  } exp_t;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   cyc       = 0;
  int   accept_cyc = 0;
  int   n_accepts = 0;

  // slave model state
  logic [15:0] s_mem  [0:255];
  logic [15:0] s_regs [0:15];
  logic        s_cpu_rst = 1'b0;
  logic [39:0] s_frame   = 40'd0;
  logic [15:0] s_reply   = 16'd0;
  int          s_rise    = 0;
  int          s_fall    = 0;
  int          s_glitch  = 0;
  bit          s_active  = 1'b0;
  bit          s_prev_clk  = 1'b0;
  bit          s_prev_mosi = 1'b0;
  bit          s_prev_cs   = 1'b1;
  bit          s_prev_rsp  = 1'b0;
  int          cs_high_run = 100;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] slave_reply(input logic [7:0] c, input logic [15:0] a);
    if (c == CMD_REG_READ) return s_regs[a[3:0]];
    if (c == CMD_MEM_READ) return s_mem[a[7:0]];
    return 16'h0000;
  endfunction

  always @(posedge system_clock) cyc <= cyc + 1;

  initial forever begin
    @(posedge system_clock);
    if (reset && req_valid && req_ready) begin
      accept_cyc = cyc;
      n_accepts++;
    end
  end

  // Slave model and response monitor share one process for a fixed order.
  initial begin
    exp_t e;
    for (int i = 0; i < 256; i++) s_mem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) s_regs[i] = 16'h1000 + 16'(i);
    s_regs[0]  = 16'h1111;
    s_regs[8]  = 16'h7FF0;
    s_regs[9]  = 16'h1234;
    s_regs[10] = 16'hA5C3;
    spi.MISO = 1'b0;
    forever begin
      @(negedge system_clock);
      if (spi.CS) begin
        s_active = 1'b0;
        spi.MISO = 1'b0;
      end else begin
        if (!s_active) begin
          s_active = 1'b1;
          s_rise = 0; s_fall = 0; s_glitch = 0; s_frame = 40'd0;
        end
        if (spi.CLK && !s_prev_clk) begin
          s_frame = {s_frame[38:0], spi.MOSI};
          s_rise++;
          if (s_rise == 24) s_reply = slave_reply(s_frame[23:16], s_frame[15:0]);
        end else if (!spi.CLK && s_prev_clk) begin
          s_fall++;
          if (s_fall >= 24 && s_fall < 40) spi.MISO = s_reply[39 - s_fall];
          if (s_fall == 40) begin
            spi.MISO = 1'b0;
            if (s_frame[39:32] == CMD_MEM_WRITE) s_mem[s_frame[23:16]] = s_frame[15:0];
            if (s_frame[39:32] == CMD_RESET_SET) s_cpu_rst = s_frame[0];
          end
        end else if (spi.CLK && s_prev_clk && (spi.MOSI != s_prev_mosi)) begin
          s_glitch++;
        end
      end
      s_prev_clk  = spi.CLK;
      s_prev_mosi = spi.MOSI;

      if (spi.CS) begin
        cs_high_run++;
      end else begin
        if (s_prev_cs) check_eq("cs_gap_ge4", 64'(cs_high_run >= 4), 1);
        cs_high_run = 0;
      end
      s_prev_cs = spi.CS;

      if (rsp_valid && s_prev_rsp) check_eq("rsp_pulse_width", 2, 1);
      if (rsp_valid && !s_prev_rsp) begin
        if (sb.size() == 0) begin
          check_eq("rsp_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check_eq("rsp_data", rsp_data, e.reply);
          check_eq("mosi_frame", s_frame, e.frame);
          check_eq("sck_rises", s_rise, 40);
          check_eq("sck_falls", s_fall, 40);
          check_eq("mosi_stable", s_glitch, 0);
          check_eq("latency", cyc - accept_cyc, LAT);
        end
      end
      s_prev_rsp = rsp_valid;
    end
  end

  task automatic issue(input logic [7:0] c, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] rep, input bit push);
    int n = 0;
    req_cmd   = c;
    req_addr  = a;
    req_data  = d;
    req_valid = 1'b1;
    if (push) sb.push_back('{frame: {c, a, d}, reply: rep});
    while (!req_ready && n < 2000) begin
      @(negedge system_clock);
      n++;
    end
    if (n >= 2000) check_eq("accept_timeout", 0, 1);
    @(negedge system_clock);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 5000) begin
      @(negedge system_clock);
      n++;
    end
    if (n >= 5000) check_eq("idle_timeout", 0, 1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge system_clock);
    check_eq("rst_cs", spi.CS, 1);
    check_eq("rst_sck", spi.CLK, 0);
    check_eq("rst_mosi", spi.MOSI, 0);
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    check_eq("rst_busy", busy, 0);
    reset = 1'b1;
    @(negedge system_clock);

    issue(CMD_REG_READ, REG_PC, 16'h0000, 16'h1234, 1'b1);
    req_valid = 1'b0;
    wait_idle();

    issue(CMD_MEM_WRITE, 16'h0100, 16'hBEEF, 16'h0000, 1'b1);
    req_valid = 1'b0;
    issue(CMD_MEM_READ, 16'h0100, 16'h0000, 16'hBEEF, 1'b1);
    req_valid = 1'b0;
    wait_idle();

    // abort mid-frame at bit 17
    issue(CMD_REG_READ, REG_SP, 16'h0000, 16'h0000, 1'b0);
    req_valid = 1'b0;
    n = 0;
    while (s_rise != 18 && n < 3000) begin
      @(negedge system_clock);
      #1;
      n++;
    end
    if (n >= 3000) check_eq("abort_wait_timeout", 0, 1);
    reset = 1'b0;
    @(negedge system_clock);
    check_eq("abort_cs", spi.CS, 1);
    check_eq("abort_sck", spi.CLK, 0);
    check_eq("abort_rsp_valid", rsp_valid, 0);
    repeat (3) @(negedge system_clock);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_req_ready", req_ready, 1);
    check_eq("abort_rsp_data", rsp_data, 0);
    reset = 1'b1;
    repeat (2) @(negedge system_clock);

    issue(CMD_REG_READ, REG_SP, 16'h0000, 16'h7FF0, 1'b1);
    req_valid = 1'b0;
    wait_idle();

    // three requests with req_valid held high throughout
    issue(CMD_REG_READ, 16'd0, 16'h0000, 16'h1111, 1'b1);
    issue(CMD_MEM_READ, 16'h0100, 16'h0000, 16'hBEEF, 1'b1);
    issue(CMD_REG_READ, REG_PS, 16'h0000, 16'hA5C3, 1'b1);
    req_valid = 1'b0;
    wait_idle();

    issue(CMD_RESET_SET, 16'h0000, 16'h0001, 16'h0000, 1'b1);
    req_valid = 1'b0;
    wait_idle();
    check_eq("cpu_rst_set", s_cpu_rst, 1);
    issue(CMD_RESET_SET, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    req_valid = 1'b0;
    wait_idle();
    check_eq("cpu_rst_clr", s_cpu_rst, 0);

    repeat (20) @(negedge system_clock);
    check_eq("accept_count", n_accepts, 10);
    check_eq("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
